instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Responder side of the program-counter fetch interface.
- Accepts an address plus a GetInstruction strobe from the PC, performs the read from instruction memory, and presents the fetched word to the decoder.
- The word is held with a valid/taken handshake.
- Sits between PC, instruction memory and decode. Newest fetch request always wins, so a branch or jump overrides any fetch already in flight.

Parameters:
ADDR_W, 32, address width (matches PCAddr)
DATA_W, 32, instruction word width
TIMEOUT, 15, max consecutive not-ready WAIT cycles before FetchFault; 0 disables timeout

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
PCAddr  input  ADDR_W  fetch address from PC
GetInstruction  input  1  fetch request strobe, sampled every rising edge
MemAddr  output  ADDR_W  instruction memory read address
MemRead  output  1  memory read request, held until MemReady
MemData  input  DATA_W  memory read data, valid when MemReady=1
MemReady  input  1  memory completes current read this cycle
Instruction  output  DATA_W  fetched instruction word
InstrValid  output  1  Instruction holds a valid word
InstrTaken  input  1  decoder consumes Instruction
Busy  output  1  registered; 1 whenever state != IDLE
FetchFault  output  1  sticky memory timeout flag

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE.
  - All outputs 0.
  - Pending register and timeout counter cleared.
  - Overrides every other input in the same cycle. A read in flight is abandoned and MemRead is low after that edge.
- Registers: state (IDLE, WAIT, HOLD), pend_valid, pend_addr, timeout counter of width clog2(TIMEOUT+1). All outputs are registered.
- IDLE:
  - If GetInstruction=1: MemAddr<=PCAddr, MemRead<=1, FetchFault<=0, counter<=0, go to WAIT.
  - Otherwise hold.
  - MemReady and InstrTaken are ignored.
- WAIT:
  - MemRead=1 and MemAddr stay stable until MemReady.
  - GetInstruction=1 in WAIT: pend_addr<=PCAddr, pend_valid<=1. A later request overwrites it (newest wins).
  - MemReady=1 with pend_valid=0: Instruction<=MemData, InstrValid<=1, MemRead<=0, go to HOLD.
  - MemReady=1 with pend_valid=1 (including a request in the same cycle): MemData is discarded as stale. MemAddr<=newest pending/current PCAddr, MemRead stays 1, counter<=0, pend_valid<=0, stay in WAIT. Memory treats each MemReady as completing exactly one read.
  - MemReady=0: counter increments. If TIMEOUT!=0 and counter==TIMEOUT-1, then FetchFault<=1, MemRead<=0, InstrValid stays 0, pend_valid<=0, go to IDLE.
- HOLD:
  - InstrValid=1. Instruction is stable until taken or superseded.
  - InstrTaken=1 and GetInstruction=0: InstrValid<=0, go to IDLE.
  - GetInstruction=1 (regardless of InstrTaken): InstrValid<=0, MemAddr<=PCAddr, MemRead<=1, counter<=0, go to WAIT. The held word is dropped if not taken.
  - MemReady is ignored.
- Latency: request at edge N gives MemRead=1 after edge N. With a zero-wait memory (MemReady=1 during the first WAIT cycle), InstrValid=1 after edge N+1, i.e. 2 cycles.
- Throughput: one instruction per 2 cycles when the decoder takes the word in the same cycle the next request arrives.
- InstrTaken while InstrValid=0: no effect.
- FetchFault is cleared only by rst or by a request accepted in IDLE.
- Instruction retains its last value after being taken. It is 0 after reset.

Test Plan:
- Basic fetch: rst 2 cycles; PCAddr=0x10, GetInstruction pulse; memory returns 0xDEADBEEF with MemReady on the first WAIT cycle. Required: MemAddr=0x10, MemRead 1 cycle, InstrValid=1 two edges after the request, Instruction=0xDEADBEEF. InstrTaken -> InstrValid=0, Busy=0.
- Wait states: MemReady delayed 5 cycles. Required: MemRead and MemAddr stable 6 cycles, then InstrValid=1 with the correct data, FetchFault=0.
- Redirect in flight: request 0x20, then request 0x80 while in WAIT, then MemReady with 0x1111. Required: 0x1111 discarded, MemAddr=0x80 with MemRead still 1. Next MemReady with 0x2222 gives Instruction=0x2222.
- Timeout: request with MemReady held 0. Required: FetchFault=1 and MemRead=0 after exactly 15 not-ready cycles, state IDLE. Next request clears FetchFault.
- HOLD supersede: InstrValid=1 with 0xAAAA not taken, new request 0x40. Required: InstrValid=0 next edge, MemAddr=0x40, MemRead=1.
- Reset mid-read: rst asserted in WAIT with a pending request. Required: MemRead=0, Busy=0, InstrValid=0 after the edge; a MemReady arriving later is ignored.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch responder: takes PC fetch requests, reads instruction
// memory, and holds the fetched word for decode with a valid/taken handshake.
// The newest request always wins, so redirects override an in-flight read.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] PCAddr,
  input  logic              GetInstruction,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRead,
  input  logic [DATA_W-1:0] MemData,
  input  logic              MemReady,
  output logic [DATA_W-1:0] Instruction,
  output logic              InstrValid,
  input  logic              InstrTaken,
  output logic              Busy,
  output logic              FetchFault
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_read_q, mem_read_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                instr_valid_q, instr_valid_d;
  logic                busy_q, busy_d;
  logic                fault_q, fault_d;

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pend_valid_q  <= 1'b0;
      pend_addr_q   <= '0;
      cnt_q         <= '0;
      mem_addr_q    <= '0;
      mem_read_q    <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_addr_q   <= pend_addr_d;
      cnt_q         <= cnt_d;
      mem_addr_q    <= mem_addr_d;
      mem_read_q    <= mem_read_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      busy_q        <= busy_d;
      fault_q       <= fault_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_addr_d   = pend_addr_q;
    cnt_d         = cnt_q;
    mem_addr_d    = mem_addr_q;
    mem_read_d    = mem_read_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;

    unique case (state_q)
      S_IDLE: begin
        if (GetInstruction) begin
          mem_addr_d = PCAddr;
          mem_read_d = 1'b1;
          fault_d    = 1'b0;
          cnt_d      = '0;
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        if (GetInstruction) begin
          pend_addr_d  = PCAddr;
          pend_valid_d = 1'b1;
        end
        if (MemReady) begin
          if (pend_valid_q || GetInstruction) begin
            // Completed read is stale: reissue at the newest address
            mem_addr_d   = GetInstruction ? PCAddr : pend_addr_q;
            cnt_d        = '0;
            pend_valid_d = 1'b0;
          end else begin
            instr_d       = MemData;
            instr_valid_d = 1'b1;
            mem_read_d    = 1'b0;
            state_d       = S_HOLD;
          end
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          fault_d      = 1'b1;
          mem_read_d   = 1'b0;
          pend_valid_d = 1'b0;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_HOLD: begin
        if (GetInstruction) begin
          instr_valid_d = 1'b0;
          mem_addr_d    = PCAddr;
          mem_read_d    = 1'b1;
          cnt_d         = '0;
          state_d       = S_WAIT;
        end else if (InstrTaken) begin
          instr_valid_d = 1'b0;
          state_d       = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign MemAddr     = mem_addr_q;
  assign MemRead     = mem_read_q;
  assign Instruction = instr_q;
  assign InstrValid  = instr_valid_q;
  assign Busy        = busy_q;
  assign FetchFault  = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_instr_fetch_unit;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] PCAddr = '0;
  logic              GetInstruction = 1'b0;
  logic [ADDR_W-1:0] MemAddr;
  logic              MemRead;
  logic [DATA_W-1:0] MemData = '0;
  logic              MemReady = 1'b0;
  logic [DATA_W-1:0] Instruction;
  logic              InstrValid;
  logic              InstrTaken = 1'b0;
  logic              Busy;
  logic              FetchFault;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .PCAddr        (PCAddr),
    .GetInstruction(GetInstruction),
    .MemAddr       (MemAddr),
    .MemRead       (MemRead),
    .MemData       (MemData),
    .MemReady      (MemReady),
    .Instruction   (Instruction),
    .InstrValid    (InstrValid),
    .InstrTaken    (InstrTaken),
    .Busy          (Busy),
    .FetchFault    (FetchFault)
  );

  always #5 clk = ~clk;

  // Transaction-level model: one outstanding read, a list of redirect
  // requests (only the newest matters), a held word, and a not-ready tally.
  bit                m_reading;
  logic [ADDR_W-1:0] m_addr;
  logic [ADDR_W-1:0] m_redirects[$];
  int                m_not_ready;
  bit                m_held;
  logic [DATA_W-1:0] m_word;
  bit                m_fault;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit gi, input logic [ADDR_W-1:0] pc,
                            input bit rdy, input logic [DATA_W-1:0] data, input bit tk);
    if (r) begin
      m_reading = 0; m_addr = '0; m_redirects.delete(); m_not_ready = 0;
      m_held = 0; m_word = '0; m_fault = 0;
    end else if (m_reading) begin
      if (gi) m_redirects.push_back(pc);
      if (rdy) begin
        if (m_redirects.size() > 0) begin
          m_addr = m_redirects[$];
          m_redirects.delete();
          m_not_ready = 0;
        end else begin
          m_word = data;
          m_held = 1;
          m_reading = 0;
        end
      end else begin
        m_not_ready++;
        if (TIMEOUT != 0 && m_not_ready == int'(TIMEOUT)) begin
          m_fault = 1;
          m_reading = 0;
          m_redirects.delete();
        end
      end
    end else if (gi) begin
      if (!m_held) m_fault = 0;
      m_held = 0;
      m_addr = pc;
      m_reading = 1;
      m_not_ready = 0;
    end else if (m_held && tk) begin
      m_held = 0;
    end
  endtask

  // One clock: drive at negedge, advance model at posedge, compare after it.
  task automatic cyc(input bit r, input bit gi, input logic [ADDR_W-1:0] pc,
                     input bit rdy, input logic [DATA_W-1:0] data, input bit tk);
    @(negedge clk);
    rst = r; GetInstruction = gi; PCAddr = pc; MemReady = rdy; MemData = data; InstrTaken = tk;
    @(posedge clk);
    model_step(r, gi, pc, rdy, data, tk);
    #1;
    check_eq("MemRead",     64'(MemRead),     64'(m_reading));
    check_eq("MemAddr",     64'(MemAddr),     64'(m_addr));
    check_eq("InstrValid",  64'(InstrValid),  64'(m_held));
    check_eq("Instruction", 64'(Instruction), 64'(m_word));
    check_eq("Busy",        64'(Busy),        64'(m_reading || m_held));
    check_eq("FetchFault",  64'(FetchFault),  64'(m_fault));
  endtask

  initial begin
    // Reset
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check_eq("rst_instr", 64'(Instruction), 64'h0);
    check_eq("rst_busy",  64'(Busy), 64'h0);

    // Basic fetch, zero-wait memory
    cyc(0, 1, 32'h10, 0, 0, 0);
    check_eq("basic_memaddr", 64'(MemAddr), 64'h10);
    check_eq("basic_memread", 64'(MemRead), 64'h1);
    cyc(0, 0, 0, 1, 32'hDEADBEEF, 0);
    check_eq("basic_valid", 64'(InstrValid), 64'h1);
    check_eq("basic_instr", 64'(Instruction), 64'hDEADBEEF);
    check_eq("basic_rd_off", 64'(MemRead), 64'h0);
    cyc(0, 0, 0, 0, 0, 1);
    check_eq("basic_taken", 64'(InstrValid), 64'h0);
    check_eq("basic_idle", 64'(Busy), 64'h0);
    check_eq("basic_keep", 64'(Instruction), 64'hDEADBEEF);

    // Wait states
    cyc(0, 1, 32'h14, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 32'h0BAD0BAD, 0);
      check_eq("ws_stable_addr", 64'(MemAddr), 64'h14);
    end
    cyc(0, 0, 0, 1, 32'h12345678, 0);
    check_eq("ws_instr", 64'(Instruction), 64'h12345678);
    check_eq("ws_nofault", 64'(FetchFault), 64'h0);
    cyc(0, 0, 0, 0, 0, 1);

    // Redirect while reading
    cyc(0, 1, 32'h20, 0, 0, 0);
    cyc(0, 1, 32'h80, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h1111, 0);
    check_eq("redir_addr", 64'(MemAddr), 64'h80);
    check_eq("redir_rd", 64'(MemRead), 64'h1);
    check_eq("redir_stale", 64'(InstrValid), 64'h0);
    cyc(0, 0, 0, 1, 32'h2222, 0);
    check_eq("redir_instr", 64'(Instruction), 64'h2222);
    cyc(0, 0, 0, 0, 0, 1);

    // Timeout
    cyc(0, 1, 32'h30, 0, 0, 0);
    for (int i = 0; i < 14; i++) cyc(0, 0, 0, 0, 0, 0);
    check_eq("to_not_yet", 64'(FetchFault), 64'h0);
    cyc(0, 0, 0, 0, 0, 0);
    check_eq("to_fault", 64'(FetchFault), 64'h1);
    check_eq("to_rd_off", 64'(MemRead), 64'h0);
    check_eq("to_idle", 64'(Busy), 64'h0);
    cyc(0, 1, 32'h34, 0, 0, 0);
    check_eq("to_clear", 64'(FetchFault), 64'h0);
    cyc(0, 0, 0, 1, 32'h3434, 0);
    cyc(0, 0, 0, 0, 0, 1);

    // Held word superseded by a new request
    cyc(0, 1, 32'h38, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'hAAAA, 0);
    cyc(0, 1, 32'h40, 0, 0, 0);
    check_eq("sup_valid", 64'(InstrValid), 64'h0);
    check_eq("sup_addr", 64'(MemAddr), 64'h40);
    check_eq("sup_rd", 64'(MemRead), 64'h1);
    cyc(0, 0, 0, 1, 32'h4040, 0);
    cyc(0, 0, 0, 0, 0, 1);

    // Reset during a read with a pending redirect
    cyc(0, 1, 32'h50, 0, 0, 0);
    cyc(0, 1, 32'h60, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check_eq("rr_rd", 64'(MemRead), 64'h0);
    check_eq("rr_busy", 64'(Busy), 64'h0);
    cyc(0, 0, 0, 1, 32'h5555, 0);
    check_eq("rr_ignored", 64'(InstrValid), 64'h0);

    // Randomized traffic with occasional long stalls and rare resets
    for (int n = 0; n < 4000; n++) begin
      bit r, gi, rdy, tk;
      logic [ADDR_W-1:0] pc;
      r   = ($urandom_range(0, 199) == 0);
      gi  = ($urandom_range(0, 99) < 30);
      pc  = {16'h0, 16'($urandom) & 16'hFFFC};
      tk  = ($urandom_range(0, 1) == 1);
      rdy = ((n / 64) % 4 == 3) ? 1'b0 : ($urandom_range(0, 99) < 40);
      if ((n / 64) % 4 == 3) gi = ($urandom_range(0, 99) < 3);
      cyc(r, gi, pc, rdy, $urandom, tk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
